svn_seg_scan_driver: RTL and testbench

//  Time-multiplexed N-digit seven-segment display driver. Drives a common-anode display.

---
 rtl/svn_seg_pkg.sv | 21 ++
 rtl/seg7_hex_decode.sv | 12 +
 rtl/svn_seg_scan_driver.sv | 130 +++++++++++++
 tb/tb_svn_seg_scan_driver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/svn_seg_pkg.sv
// Shared constants for the seven-segment scan driver: blank code, active-low hex glyphs, width helper.
// Pure constants; no latency or flow control involved.
package svn_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Never returns less than 1 so single-digit builds still get a legal index vector.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph.
// Zero latency; no flow control.
module seg7_hex_decode
  import svn_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/svn_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with per-frame input snapshot.
// seg/dp/an are registered (1 cycle after cnt/idx/display_on); no backpressure, free-running scan.
module svn_seg_scan_driver
  import svn_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    display_on,
  input  logic                    lzb_en,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CNT_W = clog2(SCAN_DIV);
  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    frame_load;

  logic [4*NUM_DIGITS-1:0] snap_data;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_en;
  logic                    snap_lzb;

  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic                    cur_en;
  logic                    cur_lead_zero;
  logic                    zeros_above;
  logic [6:0]              dec_seg;

  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   an_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign frame_load = (cnt == '0) && (idx == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_data   <= '0;
      snap_dp     <= '0;
      snap_en     <= '0;
      snap_lzb    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_load;
      if (frame_load) begin
        snap_data <= data_in;
        snap_dp   <= dp_in;
        snap_en   <= digit_en;
        snap_lzb  <= lzb_en;
      end
    end
  end

  // Walk from the most significant digit down so zeros_above covers digits idx..NUM_DIGITS-1.
  always_comb begin
    cur_nibble    = 4'h0;
    cur_dp        = 1'b0;
    cur_en        = 1'b0;
    cur_lead_zero = 1'b0;
    zeros_above   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeros_above = zeros_above && (snap_data[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        cur_nibble    = snap_data[4*i +: 4];
        cur_dp        = snap_dp[i];
        cur_en        = snap_en[i];
        cur_lead_zero = zeros_above && (i != 0);
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  // A leading-zero digit keeps its anode and dp; only a disabled digit loses the dp too.
  always_comb begin
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    an_next  = '1;
    if (display_on && (cnt >= CNT_BLANK)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IDX_W'(i)) an_next[i] = 1'b0;
      end
      if (cur_en && !(snap_lzb && cur_lead_zero)) seg_next = dec_seg;
      if (cur_en && cur_dp) dp_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= seg_next;
      dp  <= dp_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_svn_seg_scan_driver.sv
// Scoreboard bench for svn_seg_scan_driver (4 digits, 8-cycle slots, 2-cycle blanking).
// Stimulus queues expected output events; a negedge monitor pops and compares them, including cycle gaps.
module tb_svn_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        display_on;
  logic        lzb_en;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  always #5 clk = ~clk;

  svn_seg_scan_driver #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (8),
    .BLANK_CYC  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .display_on  (display_on),
    .lzb_en      (lzb_en),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  // probe: compare at the very next negedge; otherwise compare at the next an change or frame_start.
  // gap: required cycles since the previous output event (0 = not checked).
  typedef struct packed {
    logic       probe;
    logic       fs;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         gap;
    int         id;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int next_id  = 0;

  task automatic push_ev(input logic probe, input logic fs, input logic [3:0] a,
                         input logic [6:0] s, input logic d, input int gap);
    exp_t e;
    e.probe = probe;
    e.fs    = fs;
    e.an    = a;
    e.seg   = s;
    e.dp    = d;
    e.gap   = gap;
    e.id    = next_id;
    next_id++;
    q.push_back(e);
  endtask

  // One frame: frame_start, then four active slots separated by blanking.
  task automatic push_frame(input int first_gap, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dp_lit);
    logic [6:0] s[4];
    logic [3:0] a;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    push_ev(1'b0, 1'b1, 4'hF, 7'h7F, 1'b1, first_gap);
    for (int i = 0; i < 4; i++) begin
      a    = 4'hF;
      a[i] = 1'b0;
      push_ev(1'b0, 1'b0, a, s[i], ~dp_lit[i], 2);
      if (i < 3) push_ev(1'b0, 1'b0, 4'hF, 7'h7F, 1'b1, 6);
    end
  endtask

  task automatic wait_size(input int n);
    do @(posedge clk); while (q.size() > n);
    #1;
  endtask

  initial begin : monitor
    exp_t       h;
    logic       ev;
    logic [3:0] prev_an;
    int         cyc;
    prev_an = 4'hF;
    cyc     = 0;
    forever begin
      @(negedge clk);
      cyc++;
      checks++;
      if (!$onehot0(~an)) begin
        failures++;
        $display("FAIL anode_onehot: an=%b, required at most one low bit", an);
      end
      ev = (an != prev_an) || (frame_start == 1'b1);
      if (q.size() != 0) begin
        h = q[0];
        if (h.probe || ev) begin
          void'(q.pop_front());
          checks++;
          if ({frame_start, an, seg, dp} !== {h.fs, h.an, h.seg, h.dp}) begin
            failures++;
            $display("FAIL ev%0d: got fs=%b an=%b seg=%h dp=%b, want fs=%b an=%b seg=%h dp=%b",
                     h.id, frame_start, an, seg, dp, h.fs, h.an, h.seg, h.dp);
          end
          if (h.gap != 0) begin
            checks++;
            if (cyc != h.gap) begin
              failures++;
              $display("FAIL ev%0d_gap: got %0d cycles, want %0d", h.id, cyc, h.gap);
            end
          end
          cyc = 0;
        end else if (cyc > 40) begin
          checks++;
          failures++;
          $display("FAIL ev%0d_timeout: no output event for %0d cycles, want one", h.id, cyc);
          q.delete();
        end
      end
      if (ev) cyc = 0;
      prev_an = an;
    end
  end

  initial begin : guard
    #100000;
    $display("FAIL global_timeout: simulation still running at 100000 ns, want completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    rst        = 1'b1;
    display_on = 1'b1;
    lzb_en     = 1'b0;
    data_in    = 16'h12AF;
    dp_in      = 4'b0100;
    digit_en   = 4'b1111;

    // Reset values, then frame A (12AF, dp on digit 2)
    push_ev(1'b1, 1'b0, 4'hF, 7'h7F, 1'b1, 0);
    push_frame(0, 7'h0E, 7'h08, 7'h24, 7'h79, 4'b0100);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Mid-frame change must not reach the display until the next frame
    wait_size(6);
    data_in = 16'h3456;
    wait_size(0);
    push_frame(6, 7'h02, 7'h12, 7'h19, 7'h30, 4'b0100);

    // Leading-zero blanking: 0070, dp of a blanked digit still lit
    wait_size(7);
    data_in = 16'h0070;
    lzb_en  = 1'b1;
    wait_size(0);
    push_frame(6, 7'h40, 7'h78, 7'h7F, 7'h7F, 4'b0100);

    // All zero: only digit 0 lit
    wait_size(7);
    data_in = 16'h0000;
    dp_in   = 4'b0000;
    wait_size(0);
    push_frame(6, 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000);

    // Disabled digit 2 blanks segments and overrides its dp
    wait_size(7);
    data_in  = 16'h12AF;
    lzb_en   = 1'b0;
    dp_in    = 4'b0100;
    digit_en = 4'b1011;
    wait_size(0);
    push_frame(6, 7'h0E, 7'h08, 7'h7F, 7'h79, 4'b0000);

    // display_on dropped in the middle of slot 1
    wait_size(7);
    digit_en = 4'b1111;
    wait_size(0);
    push_ev(1'b0, 1'b1, 4'hF, 7'h7F, 1'b1, 6);
    push_ev(1'b0, 1'b0, 4'b1110, 7'h0E, 1'b1, 2);
    push_ev(1'b0, 1'b0, 4'hF, 7'h7F, 1'b1, 6);
    push_ev(1'b0, 1'b0, 4'b1101, 7'h08, 1'b1, 2);
    wait_size(0);
    display_on = 1'b0;
    @(posedge clk); #1;
    push_ev(1'b1, 1'b0, 4'hF, 7'h7F, 1'b1, 0);
    display_on = 1'b1;
    @(posedge clk); #1;
    push_ev(1'b1, 1'b0, 4'b1101, 7'h08, 1'b1, 0);
    push_ev(1'b0, 1'b0, 4'hF, 7'h7F, 1'b1, 3);
    push_ev(1'b0, 1'b0, 4'b1011, 7'h24, 1'b0, 2);
    push_ev(1'b0, 1'b0, 4'hF, 7'h7F, 1'b1, 6);
    push_ev(1'b0, 1'b0, 4'b0111, 7'h79, 1'b1, 2);

    // Asynchronous reset mid-slot, off the clock edge; scan restarts at digit 0
    wait_size(0);
    #1 rst = 1'b1;
    push_ev(1'b1, 1'b0, 4'hF, 7'h7F, 1'b1, 0);
    repeat (3) @(posedge clk);
    data_in = 16'h3456;
    dp_in   = 4'b0001;
    push_frame(0, 7'h02, 7'h12, 7'h19, 7'h30, 4'b0001);
    #1 rst = 1'b0;

    wait_size(0);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
